// File: rtl/dac_seg_decoder_if.sv
// dac_seg_decoder_if: code input and complementary switch outputs of the DAC decoder.
// master: drives din_valid/din/dwa_en, observes switches. slave: the decoder itself.
interface dac_seg_decoder_if #(
    parameter int NBITS = 10,
    parameter int NBIN  = 6
);
    localparam int NUN = (1 << (NBITS - NBIN)) - 1;

    logic             din_valid;
    logic [NBITS-1:0] din;
    logic             dwa_en;

    logic [NBIN-1:0]  sw_bin;
    logic [NBIN-1:0]  swb_bin;
    logic [NUN-1:0]   sw_un;
    logic [NUN-1:0]   swb_un;
    logic             dout_valid;
    logic [3:0]       dwa_ptr;

    modport master (
        output din_valid,
        output din,
        output dwa_en,
        input  sw_bin,
        input  swb_bin,
        input  sw_un,
        input  swb_un,
        input  dout_valid,
        input  dwa_ptr
    );

    modport slave (
        input  din_valid,
        input  din,
        input  dwa_en,
        output sw_bin,
        output swb_bin,
        output sw_un,
        output swb_un,
        output dout_valid,
        output dwa_ptr
    );
endinterface

// File: rtl/dac_seg_decoder.sv
// dac_seg_decoder: registers a DAC code, splits it into binary LSB switches and
// unary MSB cells (optionally DWA-rotated), drives complementary switch pairs.
// Ports: clk, rst (async, active high), bus (slave modport of dac_seg_decoder_if).
module dac_seg_decoder #(
    parameter int NBITS = 10,
    parameter int NBIN  = 6
) (
    input  logic             clk,
    input  logic             rst,
    dac_seg_decoder_if.slave bus
);
    localparam int NM  = NBITS - NBIN;
    localparam int NUN = (1 << NM) - 1;
    localparam int PW  = 4;

    typedef struct packed {
        logic             valid;
        logic [NBITS-1:0] code;
    } in_stage_t;

    typedef struct packed {
        logic            valid;
        logic [NBIN-1:0] bin;
        logic [NM-1:0]   m;
        logic [NUN-1:0]  therm;
    } dec_stage_t;

    in_stage_t        s1;
    dec_stage_t       s2;
    logic [NUN-1:0]   therm_c;

    logic [NBIN-1:0]  sw_bin_q;
    logic [NBIN-1:0]  swb_bin_q;
    logic [NUN-1:0]   sw_un_q;
    logic [NUN-1:0]   swb_un_q;
    logic             dv_q;
    logic [PW-1:0]    ptr_q;

    logic [2*NUN-1:0] rot_dbl;
    logic [NUN-1:0]   rot_un;
    logic [PW:0]      ptr_sum;
    logic [PW-1:0]    ptr_wrap;
    logic [NUN-1:0]   un_c;
    logic [PW-1:0]    ptr_c;

    // Input register: code holds while idle, valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1.valid <= bus.din_valid;
            if (bus.din_valid) begin
                s1.code <= bus.din;
            end
        end
    end

    // Thermometer of the unary count, cells 0..m-1.
    always_comb begin
        therm_c = '0;
        for (int j = 0; j < NUN; j++) begin
            therm_c[j] = (j < int'(s1.code[NBITS-1:NBIN]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2 <= '0;
        end else begin
            s2.valid <= s1.valid;
            if (s1.valid) begin
                s2.bin   <= s1.code[NBIN-1:0];
                s2.m     <= s1.code[NBITS-1:NBIN];
                s2.therm <= therm_c;
            end
        end
    end

    // Rotate the thermometer left by ptr within NUN cells: the upper half
    // of the doubled word picks up the bits that wrap past cell NUN-1.
    always_comb begin
        rot_dbl = {s2.therm, s2.therm} << ptr_q;
        rot_un  = rot_dbl[2*NUN-1:NUN];
    end

    // ptr + m never exceeds 2*NUN, so one conditional subtract is a full mod.
    // m = NUN therefore leaves the pointer where it was.
    always_comb begin
        ptr_sum = (PW+1)'(ptr_q) + (PW+1)'(s2.m);
        if (ptr_sum >= (PW+1)'(NUN)) begin
            ptr_wrap = PW'(ptr_sum - (PW+1)'(NUN));
        end else begin
            ptr_wrap = PW'(ptr_sum);
        end
    end

    // dwa_en is taken live at the update edge, so a 1->0 change lands
    // on the next update with thermometer order and a zeroed pointer.
    always_comb begin
        un_c  = s2.therm;
        ptr_c = '0;
        unique case (1'b1)
            bus.dwa_en: begin
                un_c  = rot_un;
                ptr_c = ptr_wrap;
            end
            default: begin
                un_c  = s2.therm;
                ptr_c = '0;
            end
        endcase
    end

    // Both halves of each switch pair come from their own flop so the
    // pair flips on the same edge with no gate in the path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_bin_q  <= '0;
            swb_bin_q <= '1;
            sw_un_q   <= '0;
            swb_un_q  <= '1;
            dv_q      <= 1'b0;
            ptr_q     <= '0;
        end else begin
            dv_q <= s2.valid;
            if (s2.valid) begin
                sw_bin_q  <= s2.bin;
                swb_bin_q <= ~s2.bin;
                sw_un_q   <= un_c;
                swb_un_q  <= ~un_c;
                ptr_q     <= ptr_c;
            end
        end
    end

    assign bus.sw_bin     = sw_bin_q;
    assign bus.swb_bin    = swb_bin_q;
    assign bus.sw_un      = sw_un_q;
    assign bus.swb_un     = swb_un_q;
    assign bus.dout_valid = dv_q;
    assign bus.dwa_ptr    = ptr_q;

endmodule
